// File: rtl/hpdcache_refill_victim_ctrl_pkg.sv
// Shared types for the refill victim controller: cache configuration record
// and constants used when sizing the way vector.
package hpdcache_refill_victim_ctrl_pkg;

    typedef struct packed {
        int unsigned sets;
        int unsigned ways;
    } hpdcache_user_cfg_t;

    typedef struct packed {
        hpdcache_user_cfg_t u;
    } hpdcache_cfg_t;

    localparam int unsigned HPDCACHE_SINGLE_WAY = 32'd1;

endpackage

// File: rtl/hpdcache_refill_victim_ctrl_if.sv
// Signal bundle around the refill victim controller; master is the
// surrounding cache (requester, directory, selector), slave is the controller.
interface hpdcache_refill_victim_ctrl_if #(
    parameter int SET_W = 1,
    parameter int TAG_W = 1,
    parameter int WAYS  = 1
);
    import hpdcache_refill_victim_ctrl_pkg::*;

    logic             req_valid_i;
    logic             req_ready_o;
    logic [SET_W-1:0] req_set_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             dir_rd_o;
    logic [SET_W-1:0] dir_rd_set_o;
    logic [WAYS-1:0]  dir_valid_i;
    logic [WAYS-1:0]  dir_dirty_i;
    logic             repl_o;
    logic [SET_W-1:0] repl_set_o;
    logic [WAYS-1:0]  repl_dir_valid_o;
    logic             repl_updt_o;
    logic [WAYS-1:0]  victim_way_i;
    logic             evict_valid_o;
    logic             evict_ready_i;
    logic [SET_W-1:0] evict_set_o;
    logic [WAYS-1:0]  evict_way_o;
    logic             dir_wr_o;
    logic             dir_wr_gnt_i;
    logic [SET_W-1:0] dir_wr_set_o;
    logic [WAYS-1:0]  dir_wr_way_o;
    logic [TAG_W-1:0] dir_wr_tag_o;
    logic             done_o;
    logic [WAYS-1:0]  done_way_o;
    logic             busy_o;

    modport master (
        output req_valid_i, req_set_i, req_tag_i, dir_valid_i, dir_dirty_i,
               victim_way_i, evict_ready_i, dir_wr_gnt_i,
        input  req_ready_o, dir_rd_o, dir_rd_set_o, repl_o, repl_set_o,
               repl_dir_valid_o, repl_updt_o, evict_valid_o, evict_set_o,
               evict_way_o, dir_wr_o, dir_wr_set_o, dir_wr_way_o, dir_wr_tag_o,
               done_o, done_way_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_set_i, req_tag_i, dir_valid_i, dir_dirty_i,
               victim_way_i, evict_ready_i, dir_wr_gnt_i,
        output req_ready_o, dir_rd_o, dir_rd_set_o, repl_o, repl_set_o,
               repl_dir_valid_o, repl_updt_o, evict_valid_o, evict_set_o,
               evict_way_o, dir_wr_o, dir_wr_set_o, dir_wr_way_o, dir_wr_tag_o,
               done_o, done_way_o, busy_o
    );

endinterface

// File: rtl/hpdcache_refill_victim_ctrl.sv
// Refill allocation sequencer: reads the set state, asks the selector for a
// victim, writes back a dirty victim if needed, then installs the new tag.
module hpdcache_refill_victim_ctrl
    import hpdcache_refill_victim_ctrl_pkg::*;
#(
    parameter hpdcache_cfg_t hpdcacheCfg = '0,
    parameter type hpdcache_set_t        = logic,
    parameter type hpdcache_tag_t        = logic,
    parameter type hpdcache_way_vector_t = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  hpdcache_set_t        req_set_i,
    input  hpdcache_tag_t        req_tag_i,
    output logic                 dir_rd_o,
    output hpdcache_set_t        dir_rd_set_o,
    input  hpdcache_way_vector_t dir_valid_i,
    input  hpdcache_way_vector_t dir_dirty_i,
    output logic                 repl_o,
    output hpdcache_set_t        repl_set_o,
    output hpdcache_way_vector_t repl_dir_valid_o,
    output logic                 repl_updt_o,
    input  hpdcache_way_vector_t victim_way_i,
    output logic                 evict_valid_o,
    input  logic                 evict_ready_i,
    output hpdcache_set_t        evict_set_o,
    output hpdcache_way_vector_t evict_way_o,
    output logic                 dir_wr_o,
    input  logic                 dir_wr_gnt_i,
    output hpdcache_set_t        dir_wr_set_o,
    output hpdcache_way_vector_t dir_wr_way_o,
    output hpdcache_tag_t        dir_wr_tag_o,
    output logic                 done_o,
    output hpdcache_way_vector_t done_way_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIR_RD = 3'd1,
        SELECT = 3'd2,
        EVICT  = 3'd3,
        DIR_WR = 3'd4
    } state_e;

    localparam hpdcache_way_vector_t WAY0 = hpdcache_way_vector_t'(1'b1);

    state_e               r_state;
    logic                 r_req_ready;
    logic                 r_dir_rd;
    logic                 r_repl;
    logic                 r_evict;
    logic                 r_dir_wr;
    logic                 r_busy;
    hpdcache_set_t        r_set;
    hpdcache_tag_t        r_tag;
    hpdcache_way_vector_t r_victim;

    hpdcache_way_vector_t w_victim;
    logic                 w_victim_dirty;

    // A single-way cache has no choice to make, so the selector is bypassed.
    assign w_victim       = (hpdcacheCfg.u.ways == HPDCACHE_SINGLE_WAY) ? WAY0 : victim_way_i;
    assign w_victim_dirty = |(w_victim & dir_valid_i & dir_dirty_i);

    // Allocation sequencer with registered strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_dir_rd    <= 1'b0;
            r_repl      <= 1'b0;
            r_evict     <= 1'b0;
            r_dir_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_set       <= '0;
            r_tag       <= '0;
            r_victim    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_state     <= DIR_RD;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_dir_rd    <= 1'b1;
                        r_set       <= req_set_i;
                        r_tag       <= req_tag_i;
                    end
                end
                DIR_RD: begin
                    r_state  <= SELECT;
                    r_dir_rd <= 1'b0;
                    r_repl   <= 1'b1;
                end
                SELECT: begin
                    r_repl   <= 1'b0;
                    r_victim <= w_victim;
                    if (w_victim_dirty) begin
                        r_state <= EVICT;
                        r_evict <= 1'b1;
                    end else begin
                        r_state  <= DIR_WR;
                        r_dir_wr <= 1'b1;
                    end
                end
                EVICT: begin
                    if (evict_ready_i) begin
                        r_state  <= DIR_WR;
                        r_evict  <= 1'b0;
                        r_dir_wr <= 1'b1;
                    end
                end
                DIR_WR: begin
                    if (dir_wr_gnt_i) begin
                        r_state     <= IDLE;
                        r_dir_wr    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_dir_rd    <= 1'b0;
                    r_repl      <= 1'b0;
                    r_evict     <= 1'b0;
                    r_dir_wr    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Outgoing requests are cut by reset in the same cycle so a reset never
    // leaves a half-granted writeback or tag write behind.
    assign req_ready_o      = r_req_ready;
    assign busy_o           = r_busy;
    assign dir_rd_o         = r_dir_rd;
    assign dir_rd_set_o     = r_dir_rd ? r_set : '0;
    assign repl_o           = r_repl;
    assign repl_updt_o      = r_repl;
    assign repl_set_o       = r_repl ? r_set : '0;
    assign repl_dir_valid_o = r_repl ? dir_valid_i : '0;
    assign evict_valid_o    = r_evict & rst_ni;
    assign evict_set_o      = evict_valid_o ? r_set : '0;
    assign evict_way_o      = evict_valid_o ? r_victim : '0;
    assign dir_wr_o         = r_dir_wr & rst_ni;
    assign dir_wr_set_o     = dir_wr_o ? r_set : '0;
    assign dir_wr_way_o     = dir_wr_o ? r_victim : '0;
    assign dir_wr_tag_o     = dir_wr_o ? r_tag : '0;
    assign done_o           = dir_wr_o & dir_wr_gnt_i;
    assign done_way_o       = done_o ? r_victim : '0;

`ifndef HPDCACHE_ASSERT_OFF
    victim_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == SELECT && hpdcacheCfg.u.ways > HPDCACHE_SINGLE_WAY) |-> $onehot(victim_way_i));

    req_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=>
            (!req_valid_i || ($stable(req_set_i) && $stable(req_tag_i))));
`endif

endmodule

// File: tb/tb_hpdcache_refill_victim_ctrl.sv
// Scoreboard bench for the refill victim controller: each request pushes its
// expected way, latency and eviction length; a monitor checks on completion.
module tb_hpdcache_refill_victim_ctrl;
    import hpdcache_refill_victim_ctrl_pkg::*;

    localparam int SET_W = 4;
    localparam int TAG_W = 8;
    localparam int WAYS  = 4;
    localparam hpdcache_cfg_t CFG = '{u: '{sets: 32'd16, ways: 32'd4}};

    typedef logic [SET_W-1:0] set_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [WAYS-1:0]  way_t;

    typedef struct {
        set_t set;
        tag_t tag;
        way_t way;
        int   lat;
        int   ev;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    hpdcache_refill_victim_ctrl_if #(.SET_W(SET_W), .TAG_W(TAG_W), .WAYS(WAYS)) bus ();

    hpdcache_refill_victim_ctrl #(
        .hpdcacheCfg(CFG), .hpdcache_set_t(set_t),
        .hpdcache_tag_t(tag_t), .hpdcache_way_vector_t(way_t)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(bus.req_valid_i), .req_ready_o(bus.req_ready_o),
        .req_set_i(bus.req_set_i), .req_tag_i(bus.req_tag_i),
        .dir_rd_o(bus.dir_rd_o), .dir_rd_set_o(bus.dir_rd_set_o),
        .dir_valid_i(bus.dir_valid_i), .dir_dirty_i(bus.dir_dirty_i),
        .repl_o(bus.repl_o), .repl_set_o(bus.repl_set_o),
        .repl_dir_valid_o(bus.repl_dir_valid_o), .repl_updt_o(bus.repl_updt_o),
        .victim_way_i(bus.victim_way_i),
        .evict_valid_o(bus.evict_valid_o), .evict_ready_i(bus.evict_ready_i),
        .evict_set_o(bus.evict_set_o), .evict_way_o(bus.evict_way_o),
        .dir_wr_o(bus.dir_wr_o), .dir_wr_gnt_i(bus.dir_wr_gnt_i),
        .dir_wr_set_o(bus.dir_wr_set_o), .dir_wr_way_o(bus.dir_wr_way_o),
        .dir_wr_tag_o(bus.dir_wr_tag_o),
        .done_o(bus.done_o), .done_way_o(bus.done_way_o), .busy_o(bus.busy_o)
    );

    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t exp_q[$];
    int   cyc = 0;

    way_t cur_valid, cur_dirty, cur_victim;
    int   ev_wait, gnt_wait;
    logic spurious;

    int   in_alloc = 0, acc_cyc = 0, ev_seen = 0, last_done = 0, acc_gap = 0;

    assign bus.dir_valid_i  = cur_valid;
    assign bus.dir_dirty_i  = cur_dirty;
    assign bus.victim_way_i = cur_victim;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Writeback and tag-write responders with programmable backpressure.
    initial begin
        int ev_cnt, gnt_cnt;
        ev_cnt = 0;
        gnt_cnt = 0;
        bus.evict_ready_i = 1'b0;
        bus.dir_wr_gnt_i  = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            bus.evict_ready_i = bus.evict_valid_o ? (ev_cnt == ev_wait) : spurious;
            ev_cnt = bus.evict_valid_o ? ev_cnt + 1 : 0;
            bus.dir_wr_gnt_i = bus.dir_wr_o ? (gnt_cnt == gnt_wait) : spurious;
            gnt_cnt = bus.dir_wr_o ? gnt_cnt + 1 : 0;
        end
    end

    // Output monitor and scoreboard consumer.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            in_alloc = 0;
            check_eq("done_in_reset", 64'(bus.done_o), 64'd0);
        end else begin
            if (in_alloc != 0)
                check_eq("ready_while_busy", 64'({bus.req_ready_o, bus.busy_o}), 64'd1);
            if (!bus.dir_rd_o)      check_eq("dir_rd_set_idle", 64'(bus.dir_rd_set_o), 64'd0);
            if (!bus.repl_o)        check_eq("repl_idle", 64'({bus.repl_set_o, bus.repl_dir_valid_o}), 64'd0);
            if (!bus.evict_valid_o) check_eq("evict_idle", 64'({bus.evict_set_o, bus.evict_way_o}), 64'd0);
            if (!bus.dir_wr_o)      check_eq("dir_wr_idle", 64'({bus.dir_wr_set_o, bus.dir_wr_way_o, bus.dir_wr_tag_o}), 64'd0);
            if (!bus.done_o)        check_eq("done_way_idle", 64'(bus.done_way_o), 64'd0);
            check_eq("repl_updt", 64'(bus.repl_updt_o), 64'(bus.repl_o));
            if (exp_q.size() != 0) begin
                if (bus.dir_rd_o) check_eq("dir_rd_set", 64'(bus.dir_rd_set_o), 64'(exp_q[0].set));
                if (bus.repl_o) begin
                    check_eq("repl_set", 64'(bus.repl_set_o), 64'(exp_q[0].set));
                    check_eq("repl_dir_valid", 64'(bus.repl_dir_valid_o), 64'(cur_valid));
                end
                if (bus.evict_valid_o) begin
                    ev_seen++;
                    check_eq("evict_set_way", 64'({bus.evict_set_o, bus.evict_way_o}),
                             64'({exp_q[0].set, exp_q[0].way}));
                end
                if (bus.dir_wr_o)
                    check_eq("dir_wr_fields", 64'({bus.dir_wr_set_o, bus.dir_wr_way_o, bus.dir_wr_tag_o}),
                             64'({exp_q[0].set, exp_q[0].way, exp_q[0].tag}));
            end
            if (bus.done_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("done_unexpected", 64'(bus.done_o), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("done_way", 64'(bus.done_way_o), 64'(e.way));
                    check_eq("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                    check_eq("evict_cycles", 64'(ev_seen), 64'(e.ev));
                end
                in_alloc = 0;
                last_done = cyc;
            end
            if (bus.req_valid_i && bus.req_ready_o) begin
                in_alloc = 1;
                acc_cyc  = cyc;
                ev_seen  = 0;
                acc_gap  = cyc - last_done;
            end
        end
    end

    task automatic issue(input set_t s, input tag_t t, input bit keep);
        exp_t e;
        int   n;
        e.set = s;
        e.tag = t;
        e.way = cur_victim;
        e.ev  = (|(cur_victim & cur_valid & cur_dirty)) ? ev_wait + 1 : 0;
        e.lat = 3 + e.ev + gnt_wait;
        exp_q.push_back(e);
        bus.req_valid_i = 1'b1;
        bus.req_set_i   = s;
        bus.req_tag_i   = t;
        n = 0;
        while (!bus.req_ready_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!bus.req_ready_o) begin
            check_eq("accept_timeout", 64'(bus.req_ready_o), 64'd1);
            bus.req_valid_i = 1'b0;
            void'(exp_q.pop_back());
        end else begin
            @(posedge clk_i); #1;
            if (!keep) bus.req_valid_i = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic setup(input way_t v, input way_t d, input way_t vic, input int ew, input int gw, input logic sp);
        cur_valid  = v;
        cur_dirty  = d;
        cur_victim = vic;
        ev_wait    = ew;
        gnt_wait   = gw;
        spurious   = sp;
    endtask

    initial begin
        int n;
        rst_ni = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_set_i   = '0;
        bus.req_tag_i   = '0;
        setup(4'b1111, 4'b0000, 4'b0001, 0, 0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_ready", 64'(bus.req_ready_o), 64'd1);
        check_eq("rst_strobes", 64'({bus.dir_rd_o, bus.repl_o, bus.repl_updt_o, bus.evict_valid_o,
                                     bus.dir_wr_o, bus.done_o, bus.busy_o}), 64'd0);
        check_eq("rst_fields", 64'({bus.dir_wr_set_o, bus.dir_wr_way_o, bus.dir_wr_tag_o, bus.done_way_o}), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Clean victim, dirty victim with backpressure, invalid-but-dirty.
        setup(4'b1111, 4'b0000, 4'b0100, 0, 0, 1'b0);
        issue(4'd5, 8'h12, 1'b0); drain(50);
        setup(4'b1111, 4'b0100, 4'b0100, 3, 0, 1'b0);
        issue(4'd5, 8'h12, 1'b0); drain(50);
        setup(4'b1011, 4'b0100, 4'b0100, 0, 0, 1'b0);
        issue(4'd5, 8'h34, 1'b0); drain(50);
        // Tag-write backpressure.
        setup(4'b1111, 4'b0000, 4'b0010, 0, 5, 1'b0);
        issue(4'd9, 8'hA5, 1'b0); drain(50);
        // Handshakes asserted outside their states must not shortcut anything.
        setup(4'b1111, 4'b0000, 4'b1000, 0, 0, 1'b1);
        issue(4'd3, 8'h5C, 1'b0); drain(50);
        setup(4'b1111, 4'b1000, 4'b1000, 2, 0, 1'b1);
        issue(4'd3, 8'h5D, 1'b0); drain(50);
        for (int i = 0; i < 4; i++) begin
            setup(4'b1111, (i % 2 == 1) ? way_t'(1 << i) : 4'b0000, way_t'(1 << i), i, i % 3, 1'b0);
            issue(set_t'(i + 1), tag_t'(8'h30 + i), 1'b0);
            drain(50);
        end

        // Back-to-back with request held.
        setup(4'b1111, 4'b0000, 4'b0001, 0, 0, 1'b0);
        issue(4'd7, 8'h70, 1'b1);
        issue(4'd8, 8'h71, 1'b0);
        drain(50);
        check_eq("b2b_gap", 64'(acc_gap), 64'd1);

        // Reset while a writeback is pending.
        setup(4'b1111, 4'b0010, 4'b0010, 20, 0, 1'b0);
        issue(4'd2, 8'hEE, 1'b0);
        n = 0;
        while (!bus.evict_valid_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_eq("evict_reached", 64'(bus.evict_valid_o), 64'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check_eq("evict_drop", 64'({bus.evict_valid_o, bus.dir_wr_o, bus.done_o}), 64'd0);
        @(posedge clk_i); #1;
        check_eq("mid_rst_strobes", 64'({bus.dir_rd_o, bus.repl_o, bus.repl_updt_o, bus.evict_valid_o,
                                         bus.dir_wr_o, bus.done_o, bus.busy_o}), 64'd0);
        check_eq("mid_rst_ready", 64'(bus.req_ready_o), 64'd1);
        exp_q.delete();
        rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check_eq("post_rst_idle", 64'({bus.req_ready_o, bus.busy_o}), 64'd2);
        setup(4'b1111, 4'b0000, 4'b0100, 0, 0, 1'b0);
        issue(4'd6, 8'h99, 1'b0); drain(50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
